// File: rtl/cm_gnt_dispatch.sv
// Grant-side dispatcher for cm_arbiter: captures the granted requester's word,
// acknowledges that requester, and presents the word on a valid/ready stream.
module cm_gnt_dispatch #(
    parameter  int DCNT      = 4,
    parameter  int DWIDTH    = 8,
    localparam int IDX_WIDTH = (DCNT > 1) ? $clog2(DCNT) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_vld,
    input  logic [IDX_WIDTH-1:0]             i_gnt,
    input  logic [DCNT-1:0][DWIDTH-1:0]      i_data,
    output logic [DCNT-1:0]                  o_ack,
    output logic                             o_busy,
    output logic                             o_err,
    output logic                             o_vld,
    output logic [IDX_WIDTH-1:0]             o_idx,
    output logic [DWIDTH-1:0]                o_data,
    input  logic                             i_rdy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH:0] DCNT_EXT = (IDX_WIDTH + 1)'(DCNT);

    state_t                state_q, state_d;
    logic [DWIDTH-1:0]     data_q, data_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DCNT-1:0]       ack_q, ack_d;
    logic                  err_q, err_d;

    logic                  in_range;
    logic                  acc;
    logic [IDX_WIDTH-1:0]  sel;

    // Out-of-range indices are forced to zero before they reach the data mux.
    always_comb begin
        in_range = ({1'b0, i_gnt} < DCNT_EXT);
        sel      = in_range ? i_gnt : '0;
        acc      = i_vld & in_range & ((state_q == IDLE) | i_rdy);

        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        ack_d    = '0;
        err_d    = i_vld & ~in_range;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (acc) begin
                    state_d = HOLD;
                end else if (i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc) begin
            data_d = i_data[sel];
            idx_d  = sel;
            ack_d  = DCNT'(1) << sel;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign o_vld  = (state_q == HOLD);
    assign o_busy = (state_q == HOLD);
    assign o_data = data_q;
    assign o_idx  = idx_q;
    assign o_ack  = ack_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_cm_gnt_dispatch.sv
// Self-checking bench for cm_gnt_dispatch: a 4-requester instance driven through
// a scoreboard, plus a 6-requester instance for out-of-range grant handling.
module tb_cm_gnt_dispatch;

    logic             i_clk;
    logic             i_rst;

    logic             i_vld;
    logic [1:0]       i_gnt;
    logic [3:0][7:0]  i_data;
    logic             i_rdy;
    logic [3:0]       o_ack;
    logic             o_busy;
    logic             o_err;
    logic             o_vld;
    logic [1:0]       o_idx;
    logic [7:0]       o_data;

    logic             s_vld;
    logic [2:0]       s_gnt;
    logic [5:0][7:0]  s_data;
    logic             s_rdy;
    logic [5:0]       s_ack;
    logic             s_busy;
    logic             s_err;
    logic             s_ovld;
    logic [2:0]       s_idx;
    logic [7:0]       s_odata;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } word_t;

    word_t sb[$];
    logic  mVld;
    int    checks;
    int    errors;

    cm_gnt_dispatch #(.DCNT(4), .DWIDTH(8)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (i_vld),
        .i_gnt  (i_gnt),
        .i_data (i_data),
        .o_ack  (o_ack),
        .o_busy (o_busy),
        .o_err  (o_err),
        .o_vld  (o_vld),
        .o_idx  (o_idx),
        .o_data (o_data),
        .i_rdy  (i_rdy)
    );

    cm_gnt_dispatch #(.DCNT(6), .DWIDTH(8)) dut6 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (s_vld),
        .i_gnt  (s_gnt),
        .i_data (s_data),
        .o_ack  (s_ack),
        .o_busy (s_busy),
        .o_err  (s_err),
        .o_vld  (s_ovld),
        .o_idx  (s_idx),
        .o_data (s_odata),
        .i_rdy  (s_rdy)
    );

    // Free-running clock, rising edge active, period 10.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle on the 4-requester instance (called #1 after a rising
    // edge), predicts transfer/accept from the bench model, then checks the
    // outputs #1 after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] g, input logic r);
        logic       acc;
        logic [3:0] expAck;
        word_t      w;
        i_vld = v;
        i_gnt = g;
        i_rdy = r;
        #1;
        if (mVld && r) begin
            w = sb.pop_front();
            checkOutput("xfer_idx", 32'(o_idx), 32'(w.idx));
            checkOutput("xfer_data", 32'(o_data), 32'(w.data));
        end
        acc    = v && (!mVld || r);
        expAck = acc ? (4'b0001 << g) : 4'b0000;
        if (acc) sb.push_back('{g, i_data[g]});
        mVld = acc || (mVld && !r);
        @(posedge i_clk);
        #1;
        checkOutput("ack", 32'(o_ack), 32'(expAck));
        checkOutput("vld", 32'(o_vld), 32'(mVld));
        checkOutput("busy", 32'(o_busy), 32'(mVld));
        checkOutput("err", 32'(o_err), 32'(0));
        checkOutput("ack_onehot0", 32'($onehot0(o_ack)), 32'(1));
        if (mVld) begin
            checkOutput("hold_idx", 32'(o_idx), 32'(sb[0].idx));
            checkOutput("hold_data", 32'(o_data), 32'(sb[0].data));
        end
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        #3;
        sb.delete();
        mVld = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mVld   = 1'b0;
        i_rst  = 1'b1;
        i_vld  = 1'b0;
        i_gnt  = 2'd0;
        i_rdy  = 1'b0;
        i_data = {8'h44, 8'h33, 8'h22, 8'h11};
        s_vld  = 1'b0;
        s_gnt  = 3'd0;
        s_rdy  = 1'b0;
        s_data = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        #12;
        $display("[TB] reset state");
        checkOutput("rst_vld", 32'(o_vld), 32'(0));
        checkOutput("rst_busy", 32'(o_busy), 32'(0));
        checkOutput("rst_ack", 32'(o_ack), 32'(0));
        checkOutput("rst_err", 32'(o_err), 32'(0));
        checkOutput("rst_data", 32'(o_data), 32'(0));
        checkOutput("rst_idx", 32'(o_idx), 32'(0));
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        $display("[TB] single grant");
        applyStimulus(1'b1, 2'd2, 1'b1);
        checkOutput("single_data", 32'(o_data), 32'h33);
        checkOutput("single_ack", 32'(o_ack), 32'b0100);
        applyStimulus(1'b0, 2'd0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 2'd3, 1'b0);
        checkOutput("bp_data", 32'(o_data), 32'h22);
        applyStimulus(1'b1, 2'd3, 1'b1);
        checkOutput("bp_load", 32'(o_data), 32'h44);
        checkOutput("bp_ack", 32'(o_ack), 32'b1000);
        applyStimulus(1'b0, 2'd0, 1'b1);

        $display("[TB] back-to-back");
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 2'(k), 1'b1);
        checkOutput("b2b_last", 32'(o_data), 32'h44);
        applyStimulus(1'b0, 2'd0, 1'b1);

        $display("[TB] reset mid-hold");
        applyStimulus(1'b1, 2'd1, 1'b0);
        i_vld = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_vld", 32'(o_vld), 32'(0));
        checkOutput("midrst_busy", 32'(o_busy), 32'(0));
        checkOutput("midrst_data", 32'(o_data), 32'(0));
        sb.delete();
        mVld = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        applyStimulus(1'b1, 2'd2, 1'b1);
        checkOutput("post_rst_data", 32'(o_data), 32'h33);
        applyStimulus(1'b0, 2'd0, 1'b1);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) i_data[$urandom_range(0, 3)] = 8'($urandom);
            applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("drain_empty", 32'(sb.size()), 32'(0));

        $display("[TB] out-of-range grant (DCNT=6)");
        doReset();
        s_vld = 1'b1;
        s_gnt = 3'd7;
        @(posedge i_clk);
        #1;
        s_vld = 1'b0;
        checkOutput("oor_err", 32'(s_err), 32'(1));
        checkOutput("oor_ack", 32'(s_ack), 32'(0));
        checkOutput("oor_vld", 32'(s_ovld), 32'(0));
        @(posedge i_clk);
        #1;
        checkOutput("oor_err_pulse", 32'(s_err), 32'(0));
        s_vld = 1'b1;
        s_gnt = 3'd5;
        @(posedge i_clk);
        #1;
        checkOutput("oor_hold_data", 32'(s_odata), 32'h66);
        checkOutput("oor_hold_ack", 32'(s_ack), 32'b100000);
        s_gnt = 3'd6;
        @(posedge i_clk);
        #1;
        s_vld = 1'b0;
        checkOutput("oor6_err", 32'(s_err), 32'(1));
        checkOutput("oor6_ack", 32'(s_ack), 32'(0));
        checkOutput("oor6_vld", 32'(s_ovld), 32'(1));
        checkOutput("oor6_data", 32'(s_odata), 32'h66);
        checkOutput("oor6_idx", 32'(s_idx), 32'(5));
        @(posedge i_clk);
        #1;
        checkOutput("oor6_err_pulse", 32'(s_err), 32'(0));
        checkOutput("oor6_still_vld", 32'(s_ovld), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cm_gnt_dispatch.md
# cm_gnt_dispatch

Grant-side companion of `cm_arbiter`: it consumes the arbiter's `o_vld`/`o_gnt` pair and does three things:
- captures the data word of the granted requester;
- returns a one-cycle acknowledge pulse to that requester so it can retire its request;
- presents the captured word on a single valid/ready output stream.

It sits directly downstream of `cm_arbiter` in any N-to-1 shared-resource path. It provides one output holding register with back-to-back throughput.

## Interface

Parameters:
- `DCNT`, 4, number of requesters (≥ 2); must match the driving arbiter
- `DWIDTH`, 8, data word width per requester
- `IDX_WIDTH`, `sclog2(DCNT)`, derived localparam; grant/index width

Ports:
- `i_clk`  in  1  clock; all logic on its rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_vld`  in  1  arbiter grant valid (from `cm_arbiter.o_vld`)
- `i_gnt`  in  `IDX_WIDTH`  granted requester index (from `cm_arbiter.o_gnt`)
- `i_data`  in  `[DCNT][DWIDTH]`  per-requester data words
- `o_ack`  out  `DCNT`  one-hot acknowledge pulse to the accepted requester
- `o_busy`  out  1  output register occupied (state HOLD)
- `o_err`  out  1  one-cycle pulse: out-of-range grant received
- `o_vld`  out  1  output word valid
- `o_idx`  out  `IDX_WIDTH`  source index of `o_data`
- `o_data`  out  `DWIDTH`  captured data word
- `i_rdy`  in  1  downstream ready

## Operation

- FSM, two states: IDLE (output register empty) and HOLD (`o_vld`=1).
- **Accept condition.** `acc = i_vld & (i_gnt < DCNT) & (state==IDLE | i_rdy)`.
- **On `acc`:**
  - register `o_data <= i_data[i_gnt]`, `o_idx <= i_gnt`, `o_ack <= onehot(i_gnt)`;
  - next state is HOLD.
- **IDLE:**
  - `acc` → HOLD.
  - Otherwise stay in IDLE.
- **HOLD:**
  - `i_rdy`=0: `o_vld`, `o_idx` and `o_data` held stable; `i_vld` ignored; no ack.
  - `i_rdy`=1 and `acc`: stay in HOLD and load the new word (back-to-back, no bubble).
  - `i_rdy`=1 and no `acc`: → IDLE.
- **Ignored grants.** A grant that is not accepted is dropped silently. The requester keeps its request asserted and the arbiter re-grants it later. The block never stores a pending grant.
- **Out-of-range grant.** `i_vld=1` with `i_gnt ≥ DCNT` is never accepted: no state change and no ack. `o_err` pulses the next cycle, whatever the state.
- **Ack.** Registered; `o_ack` is zero except for exactly one cycle per accepted grant. At most one bit is set.
- `o_busy` equals `o_vld`.
- **Data path.** Purely a register: no width change, no arithmetic. The mux index is `i_gnt` truncated to `IDX_WIDTH`. Out-of-range indices are gated before the mux.

## Timing

- **Reset (async assert).** State IDLE. `o_vld`, `o_busy`, `o_err`, `o_ack` = 0. `o_idx`, `o_data` = 0. Outputs clear immediately, without waiting for a clock edge.
- **Reset mid-HOLD.** The held word is discarded and never re-issued, and no ack is re-sent. The requester was already acked, so the loss is accepted by design.
- **Reset release.** Synchronous to `i_clk`: the first accept can occur on the first rising edge after deassertion.
- **Latency.** Grant sampled at edge N → `o_vld`, `o_data`, `o_idx` and `o_ack` all valid from edge N (visible in cycle N+1). Ack and first valid cycle coincide.
- **Throughput.** One word per cycle while `i_vld`=1 with in-range grants and `i_rdy`=1.
- **Transfer.** Occurs on any edge with `o_vld & i_rdy`.
- **Combinational paths.**
  - `i_rdy` → internal `acc` only; no output depends combinationally on any input.
  - `i_data` is sampled only on the accept edge; it may change freely at other times.

## Test plan

- **Single grant.** `DCNT`=4, `DWIDTH`=8, `i_data`={0x11,0x22,0x33,0x44} (index 0..3), `i_rdy`=1. One cycle of `i_vld`=1, `i_gnt`=2 → next cycle `o_vld`=1, `o_data`=0x33, `o_idx`=2, `o_ack`=4'b0100 for exactly one cycle. Returns to IDLE the following cycle.
- **Backpressure.** `i_rdy`=0. Grant 1 accepted, then `i_gnt`=3 held valid for 5 cycles → `o_data` stays 0x22, `o_idx`=1, and no further ack. Raise `i_rdy` with grant 3 still valid → same edge loads 0x44 and `o_ack`=4'b1000; `o_vld` never drops.
- **Back-to-back.** `i_rdy`=1, grants 0,1,2,3 on consecutive cycles → `o_data` 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Acks 0001, 0010, 0100, 1000; no bubbles.
- **Out-of-range.** `DCNT`=6 (`IDX_WIDTH`=3), `i_gnt`=7, `i_vld`=1 → `o_err` pulse one cycle. No ack, `o_vld` unchanged, state unchanged.
- **Reset mid-HOLD.** `i_rdy`=0 with a word held, then assert `i_rst` between edges → `o_vld`, `o_busy` and `o_data` go to 0 before the next edge. After release, the first grant behaves as in the single-grant scenario.
- **Random vs. arbiter.** `cm_arbiter` with `ARB_MAX` drives the block; random requests, weights and `i_rdy` for 1000 cycles. Scoreboard checks:
  - every ack bit pairs with exactly one output transfer of the matching `o_idx`/data;
  - `o_ack` is one-hot or zero every cycle.
